// File: rtl/dco_freq_ctrl.sv
// Frequency-locking controller for the ring-oscillator DCO: counts synchronised DCO edges per
// gate window and steps the tap select one position per window until the count is in tolerance.
module dco_freq_ctrl #(
  parameter int unsigned CTRL_WIDTH    = 5,
  parameter int unsigned COUNT_WIDTH   = 11,
  parameter int unsigned GATE_CYCLES   = 1024,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_TOL      = 2,
  parameter int unsigned LOCK_WINDOWS  = 4,
  parameter int unsigned INIT_SEL      = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   dco_clk_i,
  input  logic [COUNT_WIDTH-1:0] target_count_i,
  output logic [CTRL_WIDTH-1:0]  freq_sel_o,
  output logic                   dco_enable_o,
  output logic [COUNT_WIDTH-1:0] meas_count_o,
  output logic                   meas_valid_o,
  output logic                   locked_o
);

  localparam int unsigned TimerMax = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam int unsigned LockW    = $clog2(LOCK_WINDOWS + 1);

  localparam logic [TimerW-1:0]      SettleLast = TimerW'(SETTLE_CYCLES - 1);
  localparam logic [TimerW-1:0]      GateLast   = TimerW'(GATE_CYCLES - 1);
  localparam logic [LockW-1:0]       LockFull   = LockW'(LOCK_WINDOWS);
  localparam logic [CTRL_WIDTH-1:0]  SelMax     = '1;
  localparam logic [COUNT_WIDTH-1:0] CountMax   = '1;
  localparam logic signed [COUNT_WIDTH:0] TolPos = $signed((COUNT_WIDTH + 1)'(LOCK_TOL));
  localparam logic signed [COUNT_WIDTH:0] TolNeg = -TolPos;

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StUpdate} state_e;

  state_e                 state_q, state_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [COUNT_WIDTH-1:0] target_q, target_d;
  logic [CTRL_WIDTH-1:0]  sel_q, sel_d;
  logic [LockW-1:0]       lock_cnt_q, lock_cnt_d;
  logic [COUNT_WIDTH-1:0] meas_count_q, meas_count_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   sync1_q, sync2_q, hist_q;

  logic                   edge_det;
  logic signed [COUNT_WIDTH:0] err;

  assign edge_det = sync2_q & ~hist_q;
  assign err      = $signed({1'b0, target_q}) - $signed({1'b0, edge_cnt_q});

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    edge_cnt_d   = edge_cnt_q;
    target_d     = target_q;
    sel_d        = sel_q;
    lock_cnt_d   = lock_cnt_q;
    meas_count_d = meas_count_q;
    meas_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        timer_d    = '0;
        edge_cnt_d = '0;
        lock_cnt_d = '0;
        if (enable_i) state_d = StSettle;
      end
      StSettle: begin
        if (timer_q == SettleLast) begin
          state_d    = StMeasure;
          timer_d    = '0;
          edge_cnt_d = '0;
          target_d   = target_count_i;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StMeasure: begin
        if (edge_det && (edge_cnt_q != CountMax)) edge_cnt_d = edge_cnt_q + COUNT_WIDTH'(1);
        if (timer_q == GateLast) begin
          state_d = StUpdate;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StUpdate: begin
        meas_valid_d = 1'b1;
        meas_count_d = edge_cnt_q;
        // Default: select unchanged, go straight into the next window.
        state_d      = StMeasure;
        edge_cnt_d   = '0;
        target_d     = target_count_i;
        if (err > TolPos) begin
          lock_cnt_d = '0;
          if (sel_q != SelMax) begin
            sel_d   = sel_q + CTRL_WIDTH'(1);
            state_d = StSettle;
          end
        end else if (err < TolNeg) begin
          lock_cnt_d = '0;
          if (sel_q != '0) begin
            sel_d   = sel_q - CTRL_WIDTH'(1);
            state_d = StSettle;
          end
        end else if (lock_cnt_q != LockFull) begin
          lock_cnt_d = lock_cnt_q + LockW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Dropping enable abandons the window without publishing anything.
    if (!enable_i) begin
      state_d      = StIdle;
      timer_d      = '0;
      edge_cnt_d   = '0;
      lock_cnt_d   = '0;
      sel_d        = sel_q;
      meas_count_d = meas_count_q;
      meas_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      edge_cnt_q   <= '0;
      target_q     <= '0;
      sel_q        <= CTRL_WIDTH'(INIT_SEL);
      lock_cnt_q   <= '0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      edge_cnt_q   <= edge_cnt_d;
      target_q     <= target_d;
      sel_q        <= sel_d;
      lock_cnt_q   <= lock_cnt_d;
      meas_count_q <= meas_count_d;
      meas_valid_q <= meas_valid_d;
      sync1_q      <= dco_clk_i;
      sync2_q      <= sync1_q;
      hist_q       <= sync2_q;
    end
  end

  assign freq_sel_o   = sel_q;
  assign dco_enable_o = (state_q != StIdle);
  assign meas_count_o = meas_count_q;
  assign meas_valid_o = meas_valid_q;
  assign locked_o     = (lock_cnt_q == LockFull);

endmodule

// File: tb/tb_dco_freq_ctrl.sv
// Bench for dco_freq_ctrl: a DCO plant model plus a per-window reference model of the
// count/step/lock rules, driven by a scenario table and a few hand-written sequences.
module tb_dco_freq_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        dco_clk;
  logic [10:0] target;
  logic [4:0]  freq_sel;
  logic        dco_en;
  logic [10:0] meas_count;
  logic        meas_valid;
  logic        locked;

  dco_freq_ctrl dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .enable_i      (en),
    .dco_clk_i     (dco_clk),
    .target_count_i(target),
    .freq_sel_o    (freq_sel),
    .dco_enable_o  (dco_en),
    .meas_count_o  (meas_count),
    .meas_valid_o  (meas_valid),
    .locked_o      (locked)
  );

  typedef struct {
    int half;
    int tgt;
    int windows;
    int exp_sel;
    int exp_lock;
  } vec_t;

  vec_t tbl[3];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int rises[$];
  int tgt_c[$];
  int tgt_v[$];
  int model_sel, lock_run, last_v, en_cyc;
  bit first_pend, stepped, closed;
  int fixed_half, ph;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int tgt_at(input int w);
    int r = tgt_v[0];
    for (int i = 0; i < tgt_c.size(); i++) if (tgt_c[i] <= w) r = tgt_v[i];
    return r;
  endfunction

  // DCO plant: toggles every 'half' system cycles; closed-loop half period is 40 - sel.
  initial begin
    int half;
    dco_clk = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      half = closed ? 40 - int'(freq_sel) : fixed_half;
      if (ph >= half - 1) begin
        ph = 0;
        dco_clk = ~dco_clk;
        if (dco_clk) rises.push_back(cyc);
      end else begin
        ph++;
      end
    end
  end

  // Reference model, evaluated once per published window.
  initial begin
    int w, mc, err, exp_v;
    forever begin
      @(negedge clk);
      if (!rst && meas_valid) begin
        w = cyc - 1025;
        exp_v = first_pend ? en_cyc + 1041 : last_v + (stepped ? 1041 : 1025);
        chk("valid_time", cyc, exp_v);
        first_pend = 1'b0;
        last_v = cyc;
        // A rise launched after edge k is counted at edge k+3.
        mc = 0;
        foreach (rises[i]) if (rises[i] >= w - 2 && rises[i] <= cyc - 4) mc++;
        n_vec++;
        if (int'(meas_count) < mc - 1 || int'(meas_count) > mc + 1) begin
          n_err++;
          $display("FAIL meas_count: got %0d, want %0d +/-1 (cycle %0d)", meas_count, mc, cyc);
        end
        err = tgt_at(w) - int'(meas_count);
        stepped = 1'b0;
        if (err > 2) begin
          lock_run = 0;
          if (model_sel < 31) begin model_sel++; stepped = 1'b1; end
        end else if (err < -2) begin
          lock_run = 0;
          if (model_sel > 0) begin model_sel--; stepped = 1'b1; end
        end else begin
          lock_run = (lock_run < 4) ? lock_run + 1 : 4;
        end
        chk("freq_sel", int'(freq_sel), model_sel);
        chk("locked", int'(locked), (lock_run == 4) ? 1 : 0);
        while (rises.size() > 0 && rises[0] <= cyc - 4) void'(rises.pop_front());
      end
    end
  end

  task automatic set_target(input int v);
    target = 11'(v);
    tgt_c.push_back(cyc + 1);
    tgt_v.push_back(v);
  endtask

  task automatic do_reset(input int tgt);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_freq_sel", int'(freq_sel), 16);
    chk("rst_dco_en", int'(dco_en), 0);
    chk("rst_meas_count", int'(meas_count), 0);
    chk("rst_meas_valid", int'(meas_valid), 0);
    chk("rst_locked", int'(locked), 0);
    en  = 1'b0;
    rst = 1'b0;
    model_sel = 16;
    lock_run  = 0;
    stepped   = 1'b0;
    tgt_c.delete();
    tgt_v.delete();
    target = 11'(tgt);
    tgt_c.push_back(0);
    tgt_v.push_back(tgt);
  endtask

  task automatic start_enable();
    @(negedge clk);
    en = 1'b1;
    en_cyc = cyc + 1;
    first_pend = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (meas_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL valid_timeout: no meas_valid within 1200 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic run_until_lock(input int max_w);
    bit ok;
    for (int i = 0; i < max_w; i++) begin
      wait_valid(ok);
      if (!ok || locked) break;
    end
    chk("lock_reached", int'(locked), 1);
  endtask

  initial begin
    bit ok;
    int nv, t;
    rst = 1'b1;
    en = 1'b0;
    target = '0;
    closed = 1'b0;
    fixed_half = 4;
    ph = 0;
    first_pend = 1'b0;
    last_v = 0;
    en_cyc = 0;
    model_sel = 16;
    lock_run = 0;
    tgt_c.push_back(0);
    tgt_v.push_back(0);

    tbl[0] = '{4, 128, 5, 16, 1};   // match: locks, select untouched
    tbl[1] = '{4, 200, 17, 31, 0};  // too slow: climbs and saturates at 31
    tbl[2] = '{4, 10, 18, 0, 0};    // too fast: falls and saturates at 0

    for (int i = 0; i < 3; i++) begin
      do_reset(tbl[i].tgt);
      fixed_half = tbl[i].half;
      ph = int'($urandom_range(0, 3));
      start_enable();
      @(negedge clk);
      chk("dco_en_after_enable", int'(dco_en), 1);
      for (int k = 0; k < tbl[i].windows; k++) begin
        wait_valid(ok);
        if (!ok) break;
      end
      chk("final_sel", int'(freq_sel), tbl[i].exp_sel);
      chk("final_lock", int'(locked), tbl[i].exp_lock);
    end

    // Enable drop part-way through a window after lock.
    do_reset(128);
    fixed_half = 4;
    start_enable();
    for (int k = 0; k < 4; k++) begin
      wait_valid(ok);
      if (!ok) break;
    end
    chk("pre_drop_lock", int'(locked), 1);
    repeat (int'($urandom_range(450, 550))) @(negedge clk);
    en = 1'b0;
    lock_run = 0;
    @(negedge clk);
    chk("drop_dco_en", int'(dco_en), 0);
    chk("drop_locked", int'(locked), 0);
    chk("drop_freq_sel", int'(freq_sel), 16);
    nv = 0;
    repeat (1100) begin
      @(negedge clk);
      if (meas_valid) nv++;
    end
    chk("idle_no_valid", nv, 0);
    start_enable();
    wait_valid(ok);
    chk("reenable_sel", int'(freq_sel), 16);

    // Closed loop against the sel-dependent plant, then a retarget.
    do_reset(25);
    ph = int'($urandom_range(0, 20));
    closed = 1'b1;
    start_enable();
    run_until_lock(20);
    set_target(32);
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      if (!ok || !locked) break;
    end
    chk("retarget_lock_drop", int'(locked), 0);
    run_until_lock(20);

    t = int'($urandom_range(22, 36));
    set_target(t);
    run_until_lock(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
